// File: rtl/md_unit_ctrl.sv
// md_unit_ctrl: multicycle multiply/divide controller owning HI/LO.
// Timing of each mult/div is modelled with a down-counter. The result is
// computed combinationally from the operands latched at start and
// committed to HI/LO when the count reaches zero.
// Optional build macro: MDU_CANCEL_EN adds a 'cancel' input that aborts an
// op in flight, or suppresses a start / mthi / mtlo in the same cycle.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no op in flight; accepts start and mthi/mtlo
// RUN   | op in flight; cnt counts down, commit on cnt == 0
module md_unit_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [2:0]  E_mdop,
    input  logic [31:0] E_rs_val,
    input  logic [31:0] E_rt_val,
    input  logic        D_md_use,
`ifdef MDU_CANCEL_EN
    input  logic        cancel,
`endif
    output logic        start,
    output logic        busy,
    output logic        md_stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES - 1);
    localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic [2:0]  op_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic        cancel_i;
    logic        is_muldiv;

`ifdef MDU_CANCEL_EN
    assign cancel_i = cancel;
`else
    assign cancel_i = 1'b0;
`endif

    assign is_muldiv = (E_mdop >= OP_MULT) && (E_mdop <= OP_DIVU);
    assign start     = is_muldiv && !busy;
    assign md_stall  = D_md_use && (start || busy);

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] b_safe;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] quot;
    logic [31:0] rem;
    logic [31:0] res_hi;
    logic [31:0] res_lo;
    logic        res_valid;

    // Result datapath from latched operands; division works on magnitudes so
    // the 0x80000000 / -1 case wraps cleanly instead of overflowing.
    always_comb begin
        prod_s = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
        prod_u = {32'd0, a_q} * {32'd0, b_q};
        a_neg  = (op_q == OP_DIV) && a_q[31];
        b_neg  = (op_q == OP_DIV) && b_q[31];
        a_mag  = a_neg ? (32'd0 - a_q) : a_q;
        b_mag  = b_neg ? (32'd0 - b_q) : b_q;
        b_safe = (b_q == 32'd0) ? 32'd1 : b_mag;
        q_mag  = a_mag / b_safe;
        r_mag  = a_mag % b_safe;
        quot   = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
        rem    = a_neg ? (32'd0 - r_mag) : r_mag;

        res_hi    = hi;
        res_lo    = lo;
        res_valid = 1'b0;
        case (op_q)
            OP_MULT: begin
                res_hi    = prod_s[63:32];
                res_lo    = prod_s[31:0];
                res_valid = 1'b1;
            end
            OP_MULTU: begin
                res_hi    = prod_u[63:32];
                res_lo    = prod_u[31:0];
                res_valid = 1'b1;
            end
            OP_DIV, OP_DIVU: begin
                res_hi    = rem;
                res_lo    = quot;
                res_valid = (b_q != 32'd0);
            end
            default: ;
        endcase
    end

    // Sequencing FSM: start/latch, countdown, commit, mthi/mtlo writes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            cnt   <= 4'd0;
            op_q  <= 3'd0;
            a_q   <= 32'd0;
            b_q   <= 32'd0;
            hi    <= 32'd0;
            lo    <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (!cancel_i) begin
                        if (start) begin
                            op_q  <= E_mdop;
                            a_q   <= E_rs_val;
                            b_q   <= E_rt_val;
                            cnt   <= (E_mdop <= OP_MULTU) ? MULT_LOAD : DIV_LOAD;
                            state <= RUN;
                            busy  <= 1'b1;
                        end else if (E_mdop == OP_MTHI) begin
                            hi <= E_rs_val;
                        end else if (E_mdop == OP_MTLO) begin
                            lo <= E_rs_val;
                        end
                    end
                end
                RUN: begin
                    if (cancel_i) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        cnt   <= 4'd0;
                    end else if (cnt == 4'd0) begin
                        if (res_valid) begin
                            hi <= res_hi;
                            lo <= res_lo;
                        end
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_md_unit_ctrl.sv
// Testbench for md_unit_ctrl (default build, MULT_CYCLES=5, DIV_CYCLES=10).
module tb_md_unit_ctrl;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [2:0]  E_mdop = 3'd0;
    logic [31:0] E_rs_val = 32'd0;
    logic [31:0] E_rt_val = 32'd0;
    logic        D_md_use = 1'b0;
    logic        start;
    logic        busy;
    logic        md_stall;
    logic [31:0] hi;
    logic [31:0] lo;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    md_unit_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .E_mdop   (E_mdop),
        .E_rs_val (E_rs_val),
        .E_rt_val (E_rt_val),
        .D_md_use (D_md_use),
        .start    (start),
        .busy     (busy),
        .md_stall (md_stall),
        .hi       (hi),
        .lo       (lo)
    );

    typedef struct {
        logic [2:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        int          cycles;
        string       name;
    } vec_t;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cycles;
        string       name;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v);
        exp_t e;
        int   n;
        @(negedge clk);
        E_mdop   = v.op;
        E_rs_val = v.rs;
        E_rt_val = v.rt;
        #1;
        check({v.name, "_start"}, 64'(start), 64'(v.op >= 3'd1 && v.op <= 3'd4));
        e.hi     = v.exp_hi;
        e.lo     = v.exp_lo;
        e.cycles = v.cycles;
        e.name   = v.name;
        sb.push_back(e);
        @(posedge clk);
        #1;
        E_mdop   = 3'd0;
        E_rs_val = $urandom;
        E_rt_val = $urandom;
        n = 0;
        while (busy && n < 40) begin
            n++;
            @(posedge clk);
            #1;
        end
        if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL %s_sb: got empty queue expected entry", v.name);
        end else begin
            e = sb.pop_front();
            check({e.name, "_cycles"}, 64'(n), 64'(e.cycles));
            check({e.name, "_hi"}, 64'(hi), 64'(e.hi));
            check({e.name, "_lo"}, 64'(lo), 64'(e.lo));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;

        vecs.push_back('{3'd5, 32'h0000_1234, 32'h0,         32'h0000_1234, 32'h0000_0000, 0,  "mthi"});
        vecs.push_back('{3'd6, 32'h0000_5678, 32'h0,         32'h0000_1234, 32'h0000_5678, 0,  "mtlo"});
        vecs.push_back('{3'd4, 32'h0000_0007, 32'h0,         32'h0000_1234, 32'h0000_5678, 10, "divu_by0"});
        vecs.push_back('{3'd1, 32'hFFFF_FFFE, 32'h3,         32'hFFFF_FFFF, 32'hFFFF_FFFA, 5,  "mult_neg"});
        vecs.push_back('{3'd2, 32'hFFFF_FFFF, 32'h2,         32'h0000_0001, 32'hFFFF_FFFE, 5,  "multu"});
        vecs.push_back('{3'd3, 32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 10, "div_neg"});
        vecs.push_back('{3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 10, "div_ovf"});
        vecs.push_back('{3'd4, 32'd100,       32'd7,         32'h0000_0002, 32'h0000_000E, 10, "divu"});
        vecs.push_back('{3'd3, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 10, "div_negdvsr"});
        vecs.push_back('{3'd1, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, 5,  "mult_pow"});
        vecs.push_back('{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 5,  "multu_max"});
        vecs.push_back('{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 5,  "mult_min"});
        vecs.push_back('{3'd3, 32'd5,         32'h0,         32'h4000_0000, 32'h0000_0000, 10, "div_by0"});
        vecs.push_back('{3'd7, 32'hDEAD_BEEF, 32'h1,         32'h4000_0000, 32'h0000_0000, 0,  "op_rsvd"});
        vecs.push_back('{3'd0, 32'hCAFE_F00D, 32'h1,         32'h4000_0000, 32'h0000_0000, 0,  "op_none"});

        // Reset state, including combinational start/md_stall while held in reset.
        #2;
        E_mdop   = 3'd1;
        D_md_use = 1'b1;
        #1;
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_hi", 64'(hi), 64'(0));
        check("rst_lo", 64'(lo), 64'(0));
        check("rst_start", 64'(start), 64'(1));
        check("rst_stall", 64'(md_stall), 64'(1));
        E_mdop = 3'd0;
        #1;
        check("rst_stall_idle", 64'(md_stall), 64'(0));
        D_md_use = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;

        foreach (vecs[i]) run_vec(vecs[i]);

        // Stall during a mult; a div held on E_mdop through RUN is ignored,
        // then starts in the cycle busy falls.
        @(negedge clk);
        D_md_use = 1'b1;
        E_mdop   = 3'd1;
        E_rs_val = 32'd3;
        E_rt_val = 32'd5;
        #1;
        check("stall_start", 64'(md_stall), 64'(1));
        @(posedge clk);
        #1;
        E_mdop   = 3'd3;
        E_rs_val = 32'd100;
        E_rt_val = 32'd7;
        n = 0;
        while (busy && n < 40) begin
            check("stall_busy", 64'(md_stall), 64'(1));
            n++;
            @(posedge clk);
            #1;
        end
        check("b2b_mult_cycles", 64'(n), 64'(5));
        check("b2b_mult_hi", 64'(hi), 64'(0));
        check("b2b_mult_lo", 64'(lo), 64'(15));
        check("b2b_start", 64'(start), 64'(1));
        check("b2b_stall", 64'(md_stall), 64'(1));
        @(posedge clk);
        #1;
        E_mdop   = 3'd0;
        D_md_use = 1'b0;
        n = 0;
        while (busy && n < 40) begin
            n++;
            @(posedge clk);
            #1;
        end
        check("b2b_div_cycles", 64'(n), 64'(10));
        check("b2b_div_hi", 64'(hi), 64'(2));
        check("b2b_div_lo", 64'(lo), 64'(14));

        // Asynchronous reset in the middle of a div: no later commit.
        @(negedge clk);
        E_mdop   = 3'd3;
        E_rs_val = 32'd50;
        E_rt_val = 32'd7;
        @(posedge clk);
        #1;
        E_mdop = 3'd0;
        repeat (2) @(posedge clk);
        #1;
        check("midrst_busy_before", 64'(busy), 64'(1));
        #2;
        reset_n = 1'b0;
        #1;
        check("midrst_busy", 64'(busy), 64'(0));
        check("midrst_hi", 64'(hi), 64'(0));
        check("midrst_lo", 64'(lo), 64'(0));
        @(negedge clk);
        reset_n = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        check("postrst_busy", 64'(busy), 64'(0));
        check("postrst_hi", 64'(hi), 64'(0));
        check("postrst_lo", 64'(lo), 64'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
